pong_ball_engine: RTL and testbench

Per-frame game-state engine for the Pong datapath. Once per video frame it advances the ball, resolves wall and paddle collisions, detects goals, keeps both scores, and runs the serve/point/game-over sequence. Its outputs feed the pixel colour stage directly: `ball_loc_x`, `ball_loc_y`, `left_score` and `right_score`. Paddle positions come from the paddle input stage and are only read here.

---
 rtl/pong_ball_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: once-per-frame ball/score engine for the Pong datapath.
// Advances the ball on each frame tick, resolves wall and paddle bounces, detects goals,
// keeps both scores and sequences serve -> play -> point pause -> idle / game over.
//
// Ports:
//   clk                 pixel clock
//   reset               asynchronous, active-high reset
//   frame_tick_i        one-cycle pulse per frame; all position/score/pause updates use it
//   serve_i             one-cycle serve/restart pulse (honoured in IDLE and OVER only)
//   left_paddle_loc_i   top row of the left paddle
//   right_paddle_loc_i  top row of the right paddle
//   ball_loc_x_o        ball top-left column
//   ball_loc_y_o        ball top-left row
//   left_score_o        left player score
//   right_score_o       right player score
//   game_state_o        0 IDLE, 1 PLAY, 2 SCORED, 3 OVER
//   game_over_o         high while in OVER
module pong_ball_engine #(
    parameter int unsigned FIELD_X_BEGIN  = 8,
    parameter int unsigned FIELD_X_END    = 631,
    parameter int unsigned FIELD_Y_BEGIN  = 8,
    parameter int unsigned FIELD_Y_END    = 471,
    parameter int unsigned BALL_SIZE      = 8,
    parameter int unsigned SPEED          = 2,
    parameter int unsigned PADDLE_W       = 8,
    parameter int unsigned PADDLE_H       = 48,
    parameter int unsigned LEFT_PADDLE_X  = 16,
    parameter int unsigned RIGHT_PADDLE_X = 616,
    parameter int unsigned WIN_SCORE      = 9,
    parameter int unsigned PAUSE_FRAMES   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick_i,
    input  logic       serve_i,
    input  logic [9:0] left_paddle_loc_i,
    input  logic [9:0] right_paddle_loc_i,
    output logic [9:0] ball_loc_x_o,
    output logic [9:0] ball_loc_y_o,
    output logic [3:0] left_score_o,
    output logic [3:0] right_score_o,
    output logic [1:0] game_state_o,
    output logic       game_over_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StPlay   = 2'd1;
    localparam logic [1:0] StScored = 2'd2;
    localparam logic [1:0] StOver   = 2'd3;

    // All position arithmetic is 11 bits wide so sums never wrap.
    localparam logic [10:0] CX       = 11'((FIELD_X_BEGIN + FIELD_X_END + 1) / 2 - BALL_SIZE / 2);
    localparam logic [10:0] CY       = 11'((FIELD_Y_BEGIN + FIELD_Y_END + 1) / 2 - BALL_SIZE / 2);
    localparam logic [10:0] SPD      = 11'(SPEED);
    localparam logic [10:0] BALL_EXT = 11'(BALL_SIZE - 1);
    localparam logic [10:0] PAD_EXT  = 11'(PADDLE_H - 1);
    localparam logic [10:0] Y_TOP    = 11'(FIELD_Y_BEGIN);
    localparam logic [10:0] Y_TOP_LIM = 11'(FIELD_Y_BEGIN + SPEED);
    localparam logic [10:0] Y_END    = 11'(FIELD_Y_END);
    localparam logic [10:0] Y_BOT    = 11'(FIELD_Y_END - BALL_SIZE + 1);
    localparam logic [10:0] X_END    = 11'(FIELD_X_END);
    localparam logic [10:0] X_GOAL_L = 11'(FIELD_X_BEGIN + SPEED);
    localparam logic [10:0] L_FACE   = 11'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [10:0] R_LIMIT  = 11'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

    localparam int unsigned PauseW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam logic [PauseW-1:0] PAUSE_LAST = PauseW'(PAUSE_FRAMES - 1);

    logic [1:0]        state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              dx_q, dx_d, dy_q, dy_d;
    logic [3:0]        lscore_q, lscore_d, rscore_q, rscore_d;
    logic [PauseW-1:0] pause_q, pause_d;

    logic [10:0] x11, y11, nx_raw, ny_raw, nx, ny;
    logic        ndx, ndy, goal_l, goal_r;
    logic [3:0]  lscore_inc, rscore_inc;
    logic        unused_msb;

    function automatic logic overlaps(input logic [10:0] row, input logic [9:0] pad);
        logic [10:0] p;
        p = {1'b0, pad};
        return (row + BALL_EXT >= p) && (row <= p + PAD_EXT);
    endfunction

    assign x11 = {1'b0, x_q};
    assign y11 = {1'b0, y_q};

    // Bounds are checked before subtracting so the unsigned result never underflows.
    assign nx_raw = dx_q ? x11 + SPD : ((x11 >= SPD) ? x11 - SPD : 11'd0);
    assign ny_raw = dy_q ? y11 + SPD : ((y11 >= SPD) ? y11 - SPD : 11'd0);

    assign goal_l = !dx_q && (x11 < X_GOAL_L);
    assign goal_r = dx_q && (nx_raw + BALL_EXT >= X_END);

    assign lscore_inc = lscore_q + 4'd1;
    assign rscore_inc = rscore_q + 4'd1;

    // Wall bounces first, then paddle tests against the wall-corrected row.
    always_comb begin
        nx  = nx_raw;
        ny  = ny_raw;
        ndx = dx_q;
        ndy = dy_q;

        if (!dy_q && (y11 < Y_TOP_LIM)) begin
            ny  = Y_TOP;
            ndy = 1'b1;
        end else if (dy_q && (ny_raw + BALL_EXT >= Y_END)) begin
            ny  = Y_BOT;
            ndy = 1'b0;
        end

        // Only the frame that crosses the face is tested, so a missed ball keeps going.
        if (!dx_q && (x11 >= L_FACE) && (nx_raw < L_FACE) && overlaps(ny, left_paddle_loc_i)) begin
            nx  = L_FACE;
            ndx = 1'b1;
        end
        if (dx_q && (x11 <= R_LIMIT) && (nx_raw > R_LIMIT) && overlaps(ny, right_paddle_loc_i)) begin
            nx  = R_LIMIT;
            ndx = 1'b0;
        end
    end

    assign unused_msb = nx[10] ^ ny[10];

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        lscore_d = lscore_q;
        rscore_d = rscore_q;
        pause_d  = pause_q;

        case (state_q)
            StIdle: begin
                x_d = CX[9:0];
                y_d = CY[9:0];
                if (serve_i) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (frame_tick_i) begin
                    if (goal_l) begin
                        // Ball freezes where it is; the serve heads toward the conceding side.
                        rscore_d = rscore_inc;
                        dx_d     = 1'b0;
                        pause_d  = '0;
                        state_d  = (rscore_inc == WIN) ? StOver : StScored;
                    end else if (goal_r) begin
                        lscore_d = lscore_inc;
                        dx_d     = 1'b1;
                        pause_d  = '0;
                        state_d  = (lscore_inc == WIN) ? StOver : StScored;
                    end else begin
                        x_d  = nx[9:0];
                        y_d  = ny[9:0];
                        dx_d = ndx;
                        dy_d = ndy;
                    end
                end
            end
            StScored: begin
                if (frame_tick_i) begin
                    if (pause_q == PAUSE_LAST) begin
                        pause_d = '0;
                        x_d     = CX[9:0];
                        y_d     = CY[9:0];
                        dy_d    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        pause_d = pause_q + 1'b1;
                    end
                end
            end
            default: begin // StOver
                if (frame_tick_i) begin
                    x_d = CX[9:0];
                    y_d = CY[9:0];
                end
                if (serve_i) begin
                    x_d      = CX[9:0];
                    y_d      = CY[9:0];
                    lscore_d = '0;
                    rscore_d = '0;
                    dx_d     = 1'b1;
                    dy_d     = 1'b1;
                    state_d  = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            x_q      <= CX[9:0];
            y_q      <= CY[9:0];
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            lscore_q <= '0;
            rscore_q <= '0;
            pause_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            lscore_q <= lscore_d;
            rscore_q <= rscore_d;
            pause_q  <= pause_d;
        end
    end

    assign ball_loc_x_o  = x_q;
    assign ball_loc_y_o  = y_q;
    assign left_score_o  = lscore_q;
    assign right_score_o = rscore_q;
    assign game_state_o  = state_q;
    assign game_over_o   = (state_q == StOver);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: one long rally (bounces, paddle hit, left goal),
// an asynchronous mid-game reset, then a run of right goals up to game over.
module tb_pong_ball_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       serve;
    logic [9:0] left_paddle_loc;
    logic [9:0] right_paddle_loc;
    logic [9:0] ball_loc_x;
    logic [9:0] ball_loc_y;
    logic [3:0] left_score;
    logic [3:0] right_score;
    logic [1:0] game_state;
    logic       game_over;

    int total = 0;
    int bad   = 0;

    pong_ball_engine dut (
        .clk                (clk),
        .reset              (reset),
        .frame_tick_i       (frame_tick),
        .serve_i            (serve),
        .left_paddle_loc_i  (left_paddle_loc),
        .right_paddle_loc_i (right_paddle_loc),
        .ball_loc_x_o       (ball_loc_x),
        .ball_loc_y_o       (ball_loc_y),
        .left_score_o       (left_score),
        .right_score_o      (right_score),
        .game_state_o       (game_state),
        .game_over_o        (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int ex, input int ey);
        check({tag, ".x"}, 32'(ball_loc_x), 32'(ex));
        check({tag, ".y"}, 32'(ball_loc_y), 32'(ey));
    endtask

    task automatic check_status(input string tag, input int ls, input int rs, input int st);
        check({tag, ".lscore"}, 32'(left_score), 32'(ls));
        check({tag, ".rscore"}, 32'(right_score), 32'(rs));
        check({tag, ".state"}, 32'(game_state), 32'(st));
        check({tag, ".over"}, 32'(game_over), (st == 3) ? 32'd1 : 32'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_serve();
        @(negedge clk);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
    endtask

    task automatic serve_with_tick();
        @(negedge clk);
        serve      = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        serve      = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        frame_tick       = 1'b0;
        serve            = 1'b0;
        left_paddle_loc  = 10'd0;
        right_paddle_loc = 10'd380;

        // Reset values
        repeat (2) @(negedge clk);
        check_ball("rst", 316, 236);
        check_status("rst", 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        check_ball("rel", 316, 236);
        check_status("rel", 0, 0, 0);

        // Serve then first move
        pulse_serve();
        check_status("serve", 0, 0, 1);
        check_ball("serve", 316, 236);
        tick(1);
        check_ball("k1", 318, 238);

        // Bottom wall at y=462 going down
        tick(112);
        check_ball("k113", 542, 462);
        tick(1);
        check_ball("k114_bot", 544, 464);
        tick(1);
        check_ball("k115_up", 546, 462);

        // Right paddle (rows 380..427) hit
        tick(30);
        check_ball("k145", 606, 402);
        tick(1);
        check_ball("k146", 608, 400);
        tick(1);
        check_ball("k147_hit", 608, 398);
        tick(1);
        check_ball("k148_back", 606, 396);
        check_status("after_hit", 0, 0, 1);

        // Top wall
        tick(194);
        check_ball("k342", 218, 8);
        tick(1);
        check_ball("k343_top", 216, 8);
        tick(1);
        check_ball("k344_down", 214, 10);

        // Left paddle (rows 0..47) missed at row 202, then left goal
        tick(103);
        check_ball("k447", 8, 216);
        tick(1);
        check_ball("lgoal", 8, 216);
        check_status("lgoal", 0, 1, 2);

        // Serve ignored while paused; 60-frame pause
        pulse_serve();
        check_status("pause_serve", 0, 1, 2);
        tick(59);
        check_ball("pause59", 8, 216);
        check_status("pause59", 0, 1, 2);
        tick(1);
        check_ball("pause60", 316, 236);
        check_status("pause60", 0, 1, 0);

        // Idle tick does nothing; serve with coincident tick enters PLAY without moving
        tick(1);
        check_status("idle_tick", 0, 1, 0);
        serve_with_tick();
        check_status("serve_tick", 0, 1, 1);
        check_ball("serve_tick", 316, 236);
        tick(1);
        check_ball("lserve", 314, 238);
        tick(2);
        check_ball("lserve3", 310, 242);

        // Asynchronous reset mid-PLAY: checked before any clock edge
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_ball("async_rst", 316, 236);
        check_status("async_rst", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Right paddle out of the way: left player scores every rally
        right_paddle_loc = 10'd0;
        pulse_serve();
        tick(154);
        check_ball("rgoal1", 622, 386);
        check_status("rgoal1", 1, 0, 2);
        tick(60);
        check_ball("rpause", 316, 236);
        check_status("rpause", 1, 0, 0);
        pulse_serve();
        tick(1);
        check_ball("rserve", 318, 238);
        tick(153);
        check_status("rgoal2", 2, 0, 2);
        tick(60);

        for (int r = 3; r <= 8; r++) begin
            pulse_serve();
            tick(154);
            check_status($sformatf("rgoal%0d", r), r, 0, 2);
            tick(60);
        end

        // Winning point
        pulse_serve();
        tick(154);
        check_ball("win", 622, 386);
        check_status("win", 9, 0, 3);
        tick(1);
        check_ball("over1", 316, 236);
        check_status("over1", 9, 0, 3);
        tick(3);
        check_ball("over4", 316, 236);

        // Restart clears scores and serves right/down
        pulse_serve();
        check_status("restart", 0, 0, 0);
        check_ball("restart", 316, 236);
        pulse_serve();
        tick(1);
        check_ball("restart_move", 318, 238);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
